// File: rtl/sync_fifo_p.sv
// sync_fifo_p: single-clock FIFO with configurable width/depth, occupancy
// count, programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
//
// Compile-time option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through read port: an output
//                                   stage prefetches the head word and empty
//                                   reflects that stage's valid bit.
//                      undefined -> standard read port: rd_data is loaded on
//                                   the edge that accepts a read.
//
// Pointers are AW+1 bits wide. The MSB is a wrap bit, so full and empty can be
// told apart when the low address bits match. count is kept as a separate
// register, and full is decoded from the pointers alone. The two encodings
// describe the same state and must always agree.

module sync_fifo_p #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t ZERO_C = {(AW+1){1'b0}};
  localparam ptr_t ONE_C  = ptr_t'(1);
  localparam ptr_t AF_C   = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_C   = ptr_t'(AE_LEVEL);

  // Advance a pointer by one entry; the wrap bit toggles on address rollover.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ONE_C;
  endfunction

  // Pointers name the same slot but sit on different laps of the buffer.
  function automatic logic ptrs_full(input ptr_t w, input ptr_t r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  // ------------------------------------------------------------------------
  // Storage and state
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_r [DEPTH];

  ptr_t wr_ptr_r;
  ptr_t rd_ptr_r;
  ptr_t count_r;
  logic overflow_r;
  logic underflow_r;
  logic [WIDTH-1:0] rd_data_r;

  ptr_t wr_ptr_nxt_s;
  ptr_t rd_ptr_nxt_s;
  ptr_t count_nxt_s;

  logic full_s;
  logic empty_s;
  logic almost_full_s;
  logic almost_empty_s;
  logic wr_accept_s;
  logic rd_accept_s;
  logic ovf_hit_s;
  logic udf_hit_s;

  // Decode full from the pointer pair.
  always_comb begin
    full_s = ptrs_full(wr_ptr_r, rd_ptr_r);
  end

  // Threshold flags are a direct decode of the registered occupancy.
  always_comb begin
    almost_full_s  = (count_r >= AF_C);
    almost_empty_s = (count_r <= AE_C);
  end

  // Accept/reject decisions use pre-edge flags only; reset masks all requests.
  always_comb begin
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    ovf_hit_s   = 1'b0;
    udf_hit_s   = 1'b0;
    if (rst) begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
      ovf_hit_s   = 1'b0;
      udf_hit_s   = 1'b0;
    end else begin
      wr_accept_s = wr_en & ~full_s;
      rd_accept_s = rd_en & ~empty_s;
      ovf_hit_s   = wr_en & full_s;
      udf_hit_s   = rd_en & empty_s;
    end
  end

  // Next pointer and occupancy values; a simultaneous push and pop cancel.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;

    if (wr_accept_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_accept_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= ZERO_C;
      rd_ptr_r    <= ZERO_C;
      count_r     <= ZERO_C;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r  | ovf_hit_s;
      underflow_r <= underflow_r | udf_hit_s;
    end
  end

  // Storage array write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // ------------------------------------------------------------------------
  // First-word-fall-through output stage. It holds a copy of mem[rd_ptr].
  // The stored words are still counted by the pointers and count_r, so full
  // keeps its meaning. A word written at edge N only becomes visible at
  // edge N+1, because the stage reloads from words that existed before the
  // current edge.
  // ------------------------------------------------------------------------
  logic valid_r;
  logic load_s;
  logic avail_s;
  ptr_t remain_s;

  // Reader sees data only once the output stage is valid.
  always_comb begin
    empty_s = ~valid_r;
  end

  // The stage refills when it is empty or being popped. It loads only if a
  // word written before this edge remains behind the popped head.
  always_comb begin
    load_s = ~valid_r | rd_accept_s;
    if (rd_accept_s) begin
      remain_s = count_r - ONE_C;
    end else begin
      remain_s = count_r;
    end
    avail_s = (remain_s != ZERO_C);
  end

  // Output stage register: head word plus its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
    end else if (load_s) begin
      if (avail_s) begin
        rd_data_r <= mem_r[rd_ptr_nxt_s[AW-1:0]];
        valid_r   <= 1'b1;
      end else begin
        rd_data_r <= rd_data_r;
        valid_r   <= 1'b0;
      end
    end else begin
      rd_data_r <= rd_data_r;
      valid_r   <= valid_r;
    end
  end
`else
  // Standard mode: any stored word is available to the reader.
  always_comb begin
    empty_s = (count_r == ZERO_C);
  end

  // Read data register loads on an accepted pop and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end
`endif

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign rd_data      = rd_data_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = almost_full_s;
  assign almost_empty = almost_empty_s;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
